countdown_timer_core: RTL and testbench

//   Countdown timer datapath/FSM for the watch's countdown mode. Holds hours/mins/secs registers

---
 rtl/countdown_timer_core_if.sv | 24 ++
 rtl/countdown_timer_core.sv | 157 +++++++++++++++
 tb/tb_countdown_timer_core.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_core_if.sv
// Button/enable inputs and time/status outputs of the countdown timer core.
interface countdown_timer_core_if;
  logic       enable;
  logic       field_next;
  logic       inc;
  logic       start_stop;
  logic       clear;
  logic [5:0] hours;
  logic [5:0] mins;
  logic [5:0] secs;
  logic [1:0] set_field;
  logic       running;
  logic       expired;

  modport master (
    output enable, field_next, inc, start_stop, clear,
    input  hours, mins, secs, set_field, running, expired
  );

  modport slave (
    input  enable, field_next, inc, start_stop, clear,
    output hours, mins, secs, set_field, running, expired
  );
endinterface

// File: rtl/countdown_timer_core.sv
// Countdown-mode timer: field-by-field time entry, 1 Hz countdown, pause/resume, zero detection.
module countdown_timer_core #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned MAX_HOURS = 23
) (
  input logic                   clk,
  input logic                   reset,
  countdown_timer_core_if.slave bus
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [5:0]    HOURS_LAST = 6'(MAX_HOURS);

  typedef enum logic [1:0] {ST_SET, ST_RUN, ST_PAUSE, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [5:0]    hours_q, hours_d;
  logic [5:0]    mins_q, mins_d;
  logic [5:0]    secs_q, secs_d;
  logic [1:0]    field_q, field_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;

  logic       tick;
  logic       time_zero;
  logic       time_one;
  logic [5:0] dec_hours, dec_mins, dec_secs;

  assign tick      = (pre_q == PRE_LAST);
  assign time_zero = (hours_q == '0) && (mins_q == '0) && (secs_q == '0);
  assign time_one  = (hours_q == '0) && (mins_q == '0) && (secs_q == 6'd1);

  // One-second decrement with borrow; only used when time is non-zero.
  always_comb begin
    dec_hours = hours_q;
    dec_mins  = mins_q;
    dec_secs  = secs_q - 6'd1;
    if (secs_q == '0) begin
      dec_secs = 6'd59;
      dec_mins = mins_q - 6'd1;
      if (mins_q == '0) begin
        dec_mins  = 6'd59;
        dec_hours = hours_q - 6'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hours_d   = hours_q;
    mins_d    = mins_q;
    secs_d    = secs_q;
    field_d   = field_q;
    pre_d     = pre_q;
    expired_d = 1'b0;
    if (bus.enable) begin
      if (bus.clear) begin
        state_d = ST_SET;
        hours_d = '0;
        mins_d  = '0;
        secs_d  = '0;
        field_d = '0;
        pre_d   = '0;
      end else begin
        unique case (state_q)
          ST_SET: begin
            if (bus.start_stop) begin
              if (!time_zero) begin
                state_d = ST_RUN;
                field_d = '0;
                pre_d   = '0;
              end
            end else if (bus.field_next) begin
              field_d = field_q + 2'd1;
            end else if (bus.inc) begin
              unique case (field_q)
                2'd1:    secs_d  = (secs_q == 6'd59) ? '0 : secs_q + 6'd1;
                2'd2:    mins_d  = (mins_q == 6'd59) ? '0 : mins_q + 6'd1;
                2'd3:    hours_d = (hours_q >= HOURS_LAST) ? '0 : hours_q + 6'd1;
                default: ;
              endcase
            end
          end
          ST_RUN: begin
            // A tick on the start_stop cycle is still applied; reaching zero outranks the pause.
            if (tick) begin
              pre_d   = '0;
              hours_d = dec_hours;
              mins_d  = dec_mins;
              secs_d  = dec_secs;
              if (time_one) begin
                state_d   = ST_DONE;
                expired_d = 1'b1;
              end else if (bus.start_stop) begin
                state_d = ST_PAUSE;
              end
            end else if (bus.start_stop) begin
              state_d = ST_PAUSE;
            end else begin
              pre_d = pre_q + 1'b1;
            end
          end
          ST_PAUSE: begin
            if (bus.start_stop) begin
              state_d = ST_RUN;
            end else if (bus.field_next) begin
              state_d = ST_SET;
              field_d = 2'd1;
              pre_d   = '0;
            end
          end
          ST_DONE: begin
            if (bus.start_stop) begin
              state_d = ST_SET;
              field_d = '0;
            end else if (bus.field_next) begin
              state_d = ST_SET;
              field_d = 2'd1;
            end
          end
          default: state_d = ST_SET;
        endcase
      end
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SET;
      hours_q   <= '0;
      mins_q    <= '0;
      secs_q    <= '0;
      field_q   <= '0;
      pre_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hours_q   <= hours_d;
      mins_q    <= mins_d;
      secs_q    <= secs_d;
      field_q   <= field_d;
      pre_q     <= pre_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign bus.hours     = hours_q;
  assign bus.mins      = mins_q;
  assign bus.secs      = secs_q;
  assign bus.set_field = field_q;
  assign bus.running   = running_q;
  assign bus.expired   = expired_q;
endmodule

// File: tb/tb_countdown_timer_core.sv
// Scoreboard bench for countdown_timer_core: time held as total seconds in the reference model.
module tb_countdown_timer_core;
  localparam int TD   = 4;
  localparam int MAXH = 23;
  localparam int M_SET = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  countdown_timer_core_if bus();

  countdown_timer_core #(.TICK_DIV(TD), .MAX_HOURS(MAXH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [21:0] expq[$];

  int t, fld, mode, pre;
  bit ex;

  function automatic logic [21:0] expect_vec();
    return {6'(t / 3600), 6'((t / 60) % 60), 6'(t % 60), 2'(fld), (mode == M_RUN), ex};
  endfunction

  function automatic logic [21:0] actual_vec();
    return {bus.hours, bus.mins, bus.secs, bus.set_field, bus.running, bus.expired};
  endfunction

  task automatic report(input string name, input logic [21:0] a, input logic [21:0] e);
    $display("FAIL %s @%0t: got h=%0d m=%0d s=%0d f=%0d run=%0b exp=%0b, want h=%0d m=%0d s=%0d f=%0d run=%0b exp=%0b",
             name, $time, a[21:16], a[15:10], a[9:4], a[3:2], a[1], a[0],
             e[21:16], e[15:10], e[9:4], e[3:2], e[1], e[0]);
  endtask

  task automatic model_reset();
    t = 0; fld = 0; mode = M_SET; pre = 0; ex = 0;
  endtask

  task automatic model_step(input bit en, input bit fn, input bit in, input bit ss, input bit cl);
    int h, m, s;
    ex = 0;
    if (!en) return;
    if (cl) begin
      mode = M_SET; t = 0; fld = 0; pre = 0;
      return;
    end
    case (mode)
      M_SET: begin
        if (ss) begin
          if (t > 0) begin mode = M_RUN; fld = 0; pre = 0; end
        end else if (fn) begin
          fld = (fld + 1) % 4;
        end else if (in && fld != 0) begin
          h = t / 3600; m = (t / 60) % 60; s = t % 60;
          if (fld == 1) s = (s + 1) % 60;
          if (fld == 2) m = (m + 1) % 60;
          if (fld == 3) h = (h + 1) % (MAXH + 1);
          t = h * 3600 + m * 60 + s;
        end
      end
      M_RUN: begin
        pre = pre + 1;
        if (pre == TD) begin
          pre = 0;
          t = t - 1;
          if (t == 0) begin mode = M_DONE; ex = 1; end
          else if (ss) mode = M_PAUSE;
        end else if (ss) begin
          pre = pre - 1;
          mode = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (ss) mode = M_RUN;
        else if (fn) begin mode = M_SET; fld = 1; pre = 0; end
      end
      default: begin
        if (ss) begin mode = M_SET; fld = 0; end
        else if (fn) begin mode = M_SET; fld = 1; end
      end
    endcase
  endtask

  task automatic step(input bit en, input bit fn, input bit in, input bit ss, input bit cl);
    @(posedge clk);
    #2;
    bus.enable = en; bus.field_next = fn; bus.inc = in; bus.start_stop = ss; bus.clear = cl;
    model_step(en, fn, in, ss, cl);
    expq.push_back(expect_vec());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, 0, 0);
  endtask

  task automatic nexts(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    bus.enable = 1; bus.field_next = 0; bus.inc = 0; bus.start_stop = 0; bus.clear = 0;
    reset = 1'b1;
    model_reset();
    #1;
    total++;
    if (actual_vec() !== expect_vec()) begin
      bad++;
      report("async_reset", actual_vec(), expect_vec());
    end
    expq.push_back(expect_vec());
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: every settled output sample is checked against the oldest queued expectation.
  initial begin
    logic [21:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        total++;
        if (actual_vec() !== e) begin
          bad++;
          report("outputs", actual_vec(), e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running stimulus, want completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    reset = 1'b1;
    bus.enable = 0; bus.field_next = 0; bus.inc = 0; bus.start_stop = 0; bus.clear = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (actual_vec() !== expect_vec()) begin
      bad++;
      report("reset_state", actual_vec(), expect_vec());
    end
    #1;
    reset = 1'b0;

    // Field entry: secs=3, mins=2, set_field=10
    nexts(1); incs(3); nexts(1); incs(2);

    // Wrap with no carry: mins=7 then secs 59->0; hours 23->0
    step(1, 0, 0, 0, 1);
    nexts(2); incs(7); nexts(3); incs(60); nexts(2); incs(24);

    // 00:01:00 counts down to DONE, then field_next returns to SET with field 01
    step(1, 0, 0, 0, 1);
    nexts(2); incs(1); step(1, 0, 0, 1, 0);
    idle(60 * TD + 5);
    nexts(1);

    // Pause at prescaler=2, resume, tick arrives two clocks later
    step(1, 0, 0, 0, 1);
    nexts(3); incs(1); step(1, 0, 0, 1, 0);
    idle(2); step(1, 0, 0, 1, 0);
    idle(20); step(1, 0, 0, 1, 0);
    idle(3);

    // Zero time ignored by start_stop; clear beats start_stop in RUN
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0);
    nexts(1); incs(3); step(1, 0, 0, 1, 0);
    idle(5);
    step(1, 0, 0, 1, 1);
    idle(2);

    // enable=0 freezes RUN and drops pulses; then async reset mid-RUN
    step(1, 0, 0, 0, 1);
    nexts(1); incs(5); step(1, 0, 0, 1, 0);
    idle(6);
    for (int i = 0; i < 10; i++)
      step(0, ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 5) == 0);
    idle(3);
    async_reset();
    idle(3);

    for (int i = 0; i < 800; i++)
      step(($urandom % 10) != 0, ($urandom % 6) == 0, ($urandom % 3) == 0,
           ($urandom % 12) == 0, ($urandom % 60) == 0);

    repeat (3) @(posedge clk);
    #3;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
